// File: rtl/vram_fill_ctrl_pkg.sv
// Shared encodings and size constants for the nametable/attribute fill and copy engine.
package vram_fill_ctrl_pkg;

    localparam int AW      = 11;
    localparam int LW      = 12;
    localparam int SAW     = 23;
    localparam int MAX_LEN = 2048;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        COPY = 2'd1,
        ATR  = 2'd2,
        RSV  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/vram_fill_ctrl.sv
// Background fill/copy sequencer owning the CPU-side write port of the nametable and
// attribute RAMs; the CPU register path always wins the port and the engine stalls.
module vram_fill_ctrl
    import vram_fill_ctrl_pkg::*;
#(
    parameter int AW  = vram_fill_ctrl_pkg::AW,
    parameter int LW  = vram_fill_ctrl_pkg::LW,
    parameter int SAW = vram_fill_ctrl_pkg::SAW
) (
    input  logic           clk,
    input  logic           sys_rst,
    input  logic           cmd_start,
    input  logic           cmd_abort,
    input  logic [1:0]     cmd_mode,
    input  logic [AW-1:0]  cmd_dst,
    input  logic [LW-1:0]  cmd_len,
    input  logic [SAW-1:0] cmd_src,
    input  logic [7:0]     cmd_fill,
    input  logic [3:0]     cmd_atr,
    output logic           busy,
    output logic           done,
    output logic           err,
    input  logic           cpu_req,
    output logic           src_req,
    output logic [SAW-1:0] src_addr,
    input  logic           src_ack,
    input  logic [7:0]     src_dat,
    output logic [AW-1:0]  ram_addr,
    output logic [7:0]     ram_din,
    output logic           ram_we,
    output logic [3:0]     atr_din,
    output logic           atr_we
);

    state_e         state_q;
    mode_e          mode_q;
    logic [AW-1:0]  dst_q;
    logic [AW-1:0]  dst_d;
    logic [SAW-1:0] src_q;
    logic [SAW-1:0] src_d;
    logic [LW-1:0]  rem_q;
    logic [LW-1:0]  rem_d;
    logic [7:0]     fill_q;
    logic [7:0]     dat_q;
    logic [3:0]     atr_q;
    logic           err_q;
    logic           src_req_q;
    logic           len_bad;
    logic           wr_go;

    // Source pointer stops at the top of the PRG/SRM space instead of wrapping.
    function automatic logic [SAW-1:0] sat_inc(input logic [SAW-1:0] a);
        return (&a) ? a : a + SAW'(1);
    endfunction

    assign dst_d   = dst_q + AW'(1);
    assign src_d   = sat_inc(src_q);
    assign rem_d   = rem_q - LW'(1);
    assign len_bad = (mode_q == RSV) || (rem_q > LW'(MAX_LEN));

    // CPU ownership of the port masks engine writes in the same cycle.
    assign wr_go   = (state_q == WRITE) && !cpu_req;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            mode_q    <= FILL;
            dst_q     <= '0;
            src_q     <= '0;
            rem_q     <= '0;
            fill_q    <= '0;
            dat_q     <= '0;
            atr_q     <= '0;
            err_q     <= 1'b0;
            src_req_q <= 1'b0;
        end else if (cmd_abort && (state_q != IDLE)) begin
            state_q   <= IDLE;
            src_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        mode_q  <= mode_e'(cmd_mode);
                        dst_q   <= cmd_dst;
                        rem_q   <= cmd_len;
                        src_q   <= cmd_src;
                        fill_q  <= cmd_fill;
                        atr_q   <= cmd_atr;
                        err_q   <= 1'b0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (len_bad) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (rem_q == '0) begin
                        state_q <= DONE;
                    end else if (mode_q == COPY) begin
                        src_req_q <= 1'b1;
                        state_q   <= FETCH;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                FETCH: begin
                    if (src_ack) begin
                        dat_q     <= src_dat;
                        src_req_q <= 1'b0;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    if (!cpu_req) begin
                        dst_q <= dst_d;
                        src_q <= src_d;
                        rem_q <= rem_d;
                        if (rem_q == LW'(1)) begin
                            state_q <= DONE;
                        end else if (mode_q == COPY) begin
                            src_req_q <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign src_req  = src_req_q;
    assign src_addr = src_q;
    assign ram_addr = dst_q;
    assign ram_din  = (mode_q == COPY) ? dat_q : fill_q;
    assign atr_din  = atr_q;
    assign ram_we   = wr_go && (mode_q != ATR);
    assign atr_we   = wr_go;

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Directed bench for vram_fill_ctrl with a shadow model of both RAMs.
module tb_vram_fill_ctrl;

    logic        clk;
    logic        sys_rst;
    logic        cmd_start;
    logic        cmd_abort;
    logic [1:0]  cmd_mode;
    logic [10:0] cmd_dst;
    logic [11:0] cmd_len;
    logic [22:0] cmd_src;
    logic [7:0]  cmd_fill;
    logic [3:0]  cmd_atr;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_req;
    logic        src_req;
    logic [22:0] src_addr;
    logic        src_ack;
    logic [7:0]  src_dat;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [3:0]  atr_din;
    logic        atr_we;

    int vecs;
    int errs;

    logic [7:0]  nt   [2048];
    logic [3:0]  at   [2048];
    logic [10:0] wlog [2048];
    int          wr_cnt;
    int          atr_cnt;
    int          viol;
    logic        clr;

    vram_fill_ctrl dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .cmd_start(cmd_start),
        .cmd_abort(cmd_abort),
        .cmd_mode (cmd_mode),
        .cmd_dst  (cmd_dst),
        .cmd_len  (cmd_len),
        .cmd_src  (cmd_src),
        .cmd_fill (cmd_fill),
        .cmd_atr  (cmd_atr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_req  (cpu_req),
        .src_req  (src_req),
        .src_addr (src_addr),
        .src_ack  (src_ack),
        .src_dat  (src_dat),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .atr_din  (atr_din),
        .atr_we   (atr_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow RAMs; enables are stable mid-cycle, so sampling on the falling edge
    // sees exactly what the real RAM latches on the next rising edge.
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2048; i++) begin
                nt[i] <= 8'hEE;
                at[i] <= 4'hE;
            end
            wr_cnt  <= 0;
            atr_cnt <= 0;
            viol    <= 0;
        end else begin
            if (ram_we) begin
                nt[ram_addr] <= ram_din;
                if (wr_cnt < 2048) wlog[wr_cnt[10:0]] <= ram_addr;
                wr_cnt <= wr_cnt + 1;
            end
            if (atr_we) begin
                at[ram_addr] <= atr_din;
                atr_cnt <= atr_cnt + 1;
            end
            if ((ram_we || atr_we) && cpu_req) viol <= viol + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic start_job(input logic [1:0] m, input logic [10:0] d, input logic [11:0] l,
                             input logic [22:0] s, input logic [7:0] f, input logic [3:0] a);
        cmd_mode  = m;
        cmd_dst   = d;
        cmd_len   = l;
        cmd_src   = s;
        cmd_fill  = f;
        cmd_atr   = a;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    // Called in cycle 1 (LOAD); returns the cycle index in which done is seen, or -1.
    task automatic wait_done(input int lo, input int hi, output int cyc);
        int c;
        c   = 1;
        cyc = -1;
        for (int k = 0; k < 5000; k++) begin
            cpu_req = (c >= lo) && (c <= hi);
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
            step();
            c++;
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        vecs++;
        if ({busy, done, err, src_req, ram_we, atr_we, ram_addr, src_addr, ram_din, atr_din} !== 52'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, err, src_req, ram_we, atr_we, ram_addr, src_addr, ram_din, atr_din});
        end
    endtask

    task automatic test_fill();
        int cyc;
        clear_model();
        start_job(2'd0, 11'h000, 12'd1024, 23'h0, 8'h20, 4'h5);
        vecs++;
        if (busy !== 1'b1 || ram_we !== 1'b0) begin
            errs++;
            $display("FAIL fill_load: busy=%0b ram_we=%0b want 1/0", busy, ram_we);
        end
        wait_done(0, -1, cyc);
        vecs++;
        if (cyc !== 1026) begin errs++; $display("FAIL fill_done_cycle: got %0d want 1026", cyc); end
        vecs++;
        if (wr_cnt !== 1024) begin errs++; $display("FAIL fill_count: got %0d want 1024", wr_cnt); end
        vecs++;
        if (nt[11'h3FF] !== 8'h20 || at[11'h3FF] !== 4'h5) begin
            errs++;
            $display("FAIL fill_last: got %h/%h want 20/5", nt[11'h3FF], at[11'h3FF]);
        end
        vecs++;
        if (nt[11'h400] !== 8'hEE) begin errs++; $display("FAIL fill_overrun: got %h want ee", nt[11'h400]); end
        step();
        vecs++;
        if ({busy, done} !== 2'b00) begin errs++; $display("FAIL fill_after_done: got %b want 00", {busy, done}); end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [10:0] exp_a [4];
        exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        clear_model();
        start_job(2'd0, 11'h7FE, 12'd4, 23'h0, 8'h6B, 4'hA);
        wait_done(0, -1, cyc);
        vecs++;
        if (cyc !== 6 || wr_cnt !== 4) begin
            errs++;
            $display("FAIL wrap_done: cyc=%0d cnt=%0d want 6/4", cyc, wr_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (wlog[i] !== exp_a[i]) begin
                errs++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, wlog[i], exp_a[i]);
            end
        end
        vecs++;
        if (nt[11'h001] !== 8'h6B || at[11'h000] !== 4'hA) begin
            errs++;
            $display("FAIL wrap_data: got %h/%h want 6b/a", nt[11'h001], at[11'h000]);
        end
        step();
    endtask

    task automatic test_atr_only();
        int cyc;
        clear_model();
        start_job(2'd2, 11'h010, 12'd2, 23'h0, 8'h77, 4'hC);
        wait_done(0, -1, cyc);
        vecs++;
        if (cyc !== 4 || wr_cnt !== 0 || atr_cnt !== 2) begin
            errs++;
            $display("FAIL atr_counts: cyc=%0d nt=%0d atr=%0d want 4/0/2", cyc, wr_cnt, atr_cnt);
        end
        vecs++;
        if (at[11'h011] !== 4'hC || nt[11'h011] !== 8'hEE) begin
            errs++;
            $display("FAIL atr_data: got %h/%h want c/ee", at[11'h011], nt[11'h011]);
        end
        step();
    endtask

    task automatic test_copy();
        logic [7:0]  b [3];
        logic [22:0] es;
        logic [10:0] ea;
        b = '{8'hA1, 8'hB2, 8'hC3};
        clear_model();
        start_job(2'd1, 11'h120, 12'd3, 23'h7E1000, 8'hFF, 4'h9);
        for (int i = 0; i < 3; i++) begin
            es = 23'h7E1000 + 23'(i);
            ea = 11'h120 + 11'(i);
            for (int k = 0; k < 8 && src_req !== 1'b1; k++) step();
            vecs++;
            if (src_req !== 1'b1 || src_addr !== es) begin
                errs++;
                $display("FAIL copy_req%0d: req=%0b addr=%h want 1/%h", i, src_req, src_addr, es);
            end
            step();
            vecs++;
            if (src_req !== 1'b1 || wr_cnt !== i) begin
                errs++;
                $display("FAIL copy_hold%0d: req=%0b writes=%0d want 1/%0d", i, src_req, wr_cnt, i);
            end
            step();
            src_dat = b[i];
            src_ack = 1'b1;
            step();
            src_ack = 1'b0;
            src_dat = 8'h00;
            vecs++;
            if (ram_we !== 1'b1 || ram_addr !== ea || ram_din !== b[i]) begin
                errs++;
                $display("FAIL copy_write%0d: we=%0b addr=%h din=%h want 1/%h/%h", i, ram_we, ram_addr, ram_din, ea, b[i]);
            end
            step();
        end
        vecs++;
        if (done !== 1'b1) begin errs++; $display("FAIL copy_done: got %0b want 1", done); end
        vecs++;
        if (wr_cnt !== 3 || nt[11'h120] !== 8'hA1 || nt[11'h122] !== 8'hC3 || at[11'h122] !== 4'h9) begin
            errs++;
            $display("FAIL copy_ram: cnt=%0d %h %h %h want 3 a1 c3 9", wr_cnt, nt[11'h120], nt[11'h122], at[11'h122]);
        end
        step();
    endtask

    task automatic test_cpu_stall();
        int cyc;
        clear_model();
        start_job(2'd0, 11'h200, 12'd8, 23'h0, 8'h33, 4'h3);
        wait_done(4, 6, cyc);
        vecs++;
        if (cyc !== 13) begin errs++; $display("FAIL stall_done_cycle: got %0d want 13", cyc); end
        vecs++;
        if (viol !== 0) begin errs++; $display("FAIL stall_we_under_cpu: got %0d want 0", viol); end
        vecs++;
        if (wr_cnt !== 8 || nt[11'h207] !== 8'h33) begin
            errs++;
            $display("FAIL stall_ram: cnt=%0d last=%h want 8/33", wr_cnt, nt[11'h207]);
        end
        step();
    endtask

    task automatic test_errors();
        int cyc;
        logic [1:0]  tm [3];
        logic [11:0] tl [3];
        logic        te [3];
        tm = '{2'd0, 2'd0, 2'd3};
        tl = '{12'h000, 12'h801, 12'h004};
        te = '{1'b0, 1'b1, 1'b1};
        clear_model();
        for (int i = 0; i < 3; i++) begin
            start_job(tm[i], 11'h040, tl[i], 23'h0, 8'h99, 4'h1);
            wait_done(0, -1, cyc);
            vecs++;
            if (cyc !== 2 || err !== te[i]) begin
                errs++;
                $display("FAIL err_case%0d: cyc=%0d err=%0b want 2/%0b", i, cyc, err, te[i]);
            end
            step();
        end
        vecs++;
        if (wr_cnt !== 0 || atr_cnt !== 0) begin
            errs++;
            $display("FAIL err_no_writes: got %0d/%0d want 0/0", wr_cnt, atr_cnt);
        end
        start_job(2'd0, 11'h050, 12'd1, 23'h0, 8'h44, 4'h2);
        vecs++;
        if (err !== 1'b0) begin errs++; $display("FAIL err_clear: got %0b want 0", err); end
        wait_done(0, -1, cyc);
        vecs++;
        if (cyc !== 3 || nt[11'h050] !== 8'h44) begin
            errs++;
            $display("FAIL err_valid_job: cyc=%0d data=%h want 3/44", cyc, nt[11'h050]);
        end
        step();
    endtask

    task automatic test_abort();
        logic seen;
        clear_model();
        start_job(2'd0, 11'h300, 12'd16, 23'h0, 8'h5A, 4'h6);
        for (int k = 0; k < 5; k++) step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        vecs++;
        if ({busy, done, err} !== 3'b000) begin
            errs++;
            $display("FAIL abort_state: got %b want 000", {busy, done, err});
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            step();
        end
        vecs++;
        if (seen !== 1'b0) begin errs++; $display("FAIL abort_quiet: got %0b want 0", seen); end
        vecs++;
        if (wr_cnt !== 5 || nt[11'h304] !== 8'h5A || nt[11'h305] !== 8'hEE) begin
            errs++;
            $display("FAIL abort_ram: cnt=%0d %h %h want 5 5a ee", wr_cnt, nt[11'h304], nt[11'h305]);
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        start_job(2'd0, 11'h400, 12'd16, 23'h12345, 8'h11, 4'h7);
        for (int k = 0; k < 3; k++) step();
        #2;
        sys_rst = 1'b1;
        #1;
        vecs++;
        if ({busy, done, err, src_req, ram_we, atr_we, ram_addr, src_addr, ram_din, atr_din} !== 52'd0) begin
            errs++;
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {busy, done, err, src_req, ram_we, atr_we, ram_addr, src_addr, ram_din, atr_din});
        end
        #2;
        sys_rst = 1'b0;
        step();
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_idle: got %b want 00", {busy, done});
        end
        vecs++;
        if (wr_cnt !== 2 || nt[11'h401] !== 8'h11 || nt[11'h402] !== 8'hEE) begin
            errs++;
            $display("FAIL rst_mid_ram: cnt=%0d %h %h want 2 11 ee", wr_cnt, nt[11'h401], nt[11'h402]);
        end
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        clr       = 1'b0;
        sys_rst   = 1'b1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        cmd_mode  = 2'd0;
        cmd_dst   = '0;
        cmd_len   = '0;
        cmd_src   = '0;
        cmd_fill  = '0;
        cmd_atr   = '0;
        cpu_req   = 1'b0;
        src_ack   = 1'b0;
        src_dat   = '0;
        #1;
        test_reset();
        step();
        sys_rst = 1'b0;
        step();
        test_fill();
        test_wrap();
        test_atr_only();
        test_copy();
        test_cpu_stall();
        test_errors();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
